// File: rtl/fetch_unit_if.sv
// Fetch unit bus: board controls, imem handshake and pc/ir status.
// master = fetch unit side, slave = controls/imem/display side.
interface fetch_unit_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               mode_run;
    logic               step;
    logic               halt;
    logic               ld_en;
    logic [PC_W-1:0]    ld_addr;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               busy;

    modport master (
        input  mode_run, step, halt, ld_en, ld_addr, imem_data,
        output imem_addr, pc, ir, ir_valid, busy
    );

    modport slave (
        output mode_run, step, halt, ld_en, ld_addr, imem_data,
        input  imem_addr, pc, ir, ir_valid, busy
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, free-run / single-step,
// halt, PC load and a fixed-latency read of a synchronous imem.
module fetch_unit #(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 16,
    parameter int MEM_LAT  = 1,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam int LAT_W = 3;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic [LAT_W-1:0]   lat_cnt;
    logic               step_q;
    logic               step_pend;
    logic               step_rise;
    logic               trigger;

    assign step_rise = bus.step & ~step_q;
    // Run mode fetches unless halted; step mode needs a fresh or remembered rise.
    assign trigger   = bus.mode_run ? ~bus.halt : (step_rise | step_pend);

    assign bus.imem_addr = pc;
    assign bus.pc        = pc;
    assign bus.ir        = ir;
    assign bus.ir_valid  = ir_valid;
    assign bus.busy      = (state == FETCH);

    // Fetch FSM: IDLE decides load/trigger, FETCH waits out the imem latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= PC_W'(RESET_PC);
            ir        <= '0;
            ir_valid  <= 1'b0;
            lat_cnt   <= '0;
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q   <= bus.step;
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Any IDLE edge consumes or discards the pending step:
                    // a load drops it, a trigger serves it, run mode clears it.
                    step_pend <= 1'b0;
                    if (bus.ld_en) begin
                        pc <= bus.ld_addr;
                    end else if (trigger) begin
                        state   <= FETCH;
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                    end
                end
                FETCH: begin
                    // Only one step is remembered while a fetch is in flight.
                    if (!bus.mode_run && step_rise)
                        step_pend <= 1'b1;
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        ir       <= bus.imem_data;
                        ir_valid <= 1'b1;
                        pc       <= pc + PC_W'(PC_STEP);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a default instance (16-bit PC, latency 1) and a
// narrow slow one (4-bit PC, latency 3), each checked every cycle against
// a transaction-level model plus directed literal expectations.
module tb_fetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Per-instance stimulus (index 0 = default DUT, 1 = narrow DUT).
    logic        mr [2];
    logic        st [2];
    logic        hl [2];
    logic        le [2];
    logic [15:0] la [2];

    // Per-instance observed outputs, zero-extended to 16 bits.
    logic [15:0] o_pc [2];
    logic [15:0] o_ad [2];
    logic [15:0] o_ir [2];
    logic        o_vl [2];
    logic        o_bz [2];

    fetch_unit_if #(.PC_W(16), .INSTR_W(16)) if0 ();
    fetch_unit_if #(.PC_W(4),  .INSTR_W(16)) if1 ();

    assign if0.mode_run  = mr[0];
    assign if0.step      = st[0];
    assign if0.halt      = hl[0];
    assign if0.ld_en     = le[0];
    assign if0.ld_addr   = la[0];
    assign if0.imem_data = if0.imem_addr ^ 16'hA5A5;

    assign if1.mode_run  = mr[1];
    assign if1.step      = st[1];
    assign if1.halt      = hl[1];
    assign if1.ld_en     = le[1];
    assign if1.ld_addr   = la[1][3:0];
    assign if1.imem_data = {12'h000, if1.imem_addr} ^ 16'hA5A5;

    assign o_pc[0] = if0.pc;
    assign o_ad[0] = if0.imem_addr;
    assign o_ir[0] = if0.ir;
    assign o_vl[0] = if0.ir_valid;
    assign o_bz[0] = if0.busy;
    assign o_pc[1] = {12'h000, if1.pc};
    assign o_ad[1] = {12'h000, if1.imem_addr};
    assign o_ir[1] = if1.ir;
    assign o_vl[1] = if1.ir_valid;
    assign o_bz[1] = if1.busy;

    fetch_unit #(.PC_W(16), .INSTR_W(16), .MEM_LAT(1), .PC_STEP(1), .RESET_PC(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    fetch_unit #(.PC_W(4), .INSTR_W(16), .MEM_LAT(3), .PC_STEP(1), .RESET_PC(0)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    function automatic logic [15:0] pc_mask(int k);
        return (k == 0) ? 16'hFFFF : 16'h000F;
    endfunction

    function automatic int mem_lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch is a transaction that starts on a trigger edge and
    // completes exactly MEM_LAT edges later, reading mem[pc] = pc ^ A5A5.
    int          cyc;
    logic [15:0] m_pc   [2];
    logic [15:0] m_ir   [2];
    logic        m_vld  [2];
    logic        m_busy [2];
    logic        m_pend [2];
    logic        m_sq   [2];
    int          m_end  [2];
    logic        rise;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int k = 0; k < 2; k++) begin
                m_pc[k]   <= '0;
                m_ir[k]   <= '0;
                m_vld[k]  <= 1'b0;
                m_busy[k] <= 1'b0;
                m_pend[k] <= 1'b0;
                m_sq[k]   <= 1'b0;
                m_end[k]  <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                rise = st[k] & ~m_sq[k];
                m_sq[k]  <= st[k];
                m_vld[k] <= 1'b0;
                if (m_busy[k]) begin
                    if (!mr[k] && rise) m_pend[k] <= 1'b1;
                    if (cyc == m_end[k]) begin
                        m_ir[k]   <= m_pc[k] ^ 16'hA5A5;
                        m_pc[k]   <= (m_pc[k] + 16'd1) & pc_mask(k);
                        m_busy[k] <= 1'b0;
                        m_vld[k]  <= 1'b1;
                    end
                end else begin
                    m_pend[k] <= 1'b0;
                    if (le[k])
                        m_pc[k] <= la[k] & pc_mask(k);
                    else if ((mr[k] && !hl[k]) || (!mr[k] && (rise || m_pend[k]))) begin
                        m_busy[k] <= 1'b1;
                        m_end[k]  <= cyc + mem_lat(k);
                    end
                end
            end
        end
    end

    // Every-cycle compare on the falling edge, plus ir_valid pulse counters.
    int vcnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pc%0d", k),       o_pc[k], m_pc[k]);
            chk($sformatf("imem_addr%0d", k), o_ad[k], m_pc[k]);
            chk($sformatf("ir%0d", k),       o_ir[k], m_ir[k]);
            chk($sformatf("ir_valid%0d", k), 32'(o_vl[k]), 32'(m_vld[k]));
            chk($sformatf("busy%0d", k),     32'(o_bz[k]), 32'(m_busy[k]));
            if (rst_n && o_vl[k]) vcnt[k] <= vcnt[k] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int c;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mr[k] = 1'b0; st[k] = 1'b0; hl[k] = 1'b0; le[k] = 1'b0; la[k] = '0;
        end
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc",    o_pc[0], 16'h0000);
        chk("rst_ir",    o_ir[0], 16'h0000);
        chk("rst_vld",   32'(o_vl[0]), 32'd0);
        chk("rst_busy",  32'(o_bz[0]), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);

        // 1: free run, latency 1
        mr[0] = 1'b1;
        tick(1); chk("t1_busy", 32'(o_bz[0]), 32'd1); chk("t1_pc0", o_pc[0], 16'h0000);
        tick(1); chk("t1_vld", 32'(o_vl[0]), 32'd1); chk("t1_ir0", o_ir[0], 16'hA5A5); chk("t1_pc1", o_pc[0], 16'h0001);
        tick(1); chk("t1_gap", 32'(o_vl[0]), 32'd0);
        tick(1); chk("t1_ir1", o_ir[0], 16'hA5A4); chk("t1_pc2", o_pc[0], 16'h0002);
        tick(2); chk("t1_ir2", o_ir[0], 16'hA5A7); chk("t1_pc3", o_pc[0], 16'h0003);
        mr[0] = 1'b0;
        tick(2);

        // 2: single step
        le[0] = 1'b1; la[0] = 16'h0000;
        tick(1); le[0] = 1'b0;
        chk("t2_ld0", o_pc[0], 16'h0000);
        c = vcnt[0];
        for (int i = 0; i < 3; i++) begin
            st[0] = 1'b1; tick(1);
            st[0] = 1'b0; tick(3);
        end
        chk("t2_pulses", vcnt[0], c + 3);
        chk("t2_pc", o_pc[0], 16'h0003);
        st[0] = 1'b1; tick(6); st[0] = 1'b0;
        chk("t2_hold_pulses", vcnt[0], c + 4);
        chk("t2_hold_pc", o_pc[0], 16'h0004);
        tick(2);

        // 3: halt right after trigger
        c = vcnt[0];
        mr[0] = 1'b1; tick(1);
        hl[0] = 1'b1; tick(6);
        chk("t3_inflight", vcnt[0], c + 1);
        chk("t3_pc", o_pc[0], 16'h0005);
        chk("t3_busy", 32'(o_bz[0]), 32'd0);
        hl[0] = 1'b0; tick(4);
        chk("t3_resume_pc", o_pc[0], 16'h0007);
        mr[0] = 1'b0; tick(2);
        chk("t3_stop_pc", o_pc[0], 16'h0007);

        // 4: PC load, then load beats a simultaneous step
        c = vcnt[0];
        le[0] = 1'b1; la[0] = 16'h00F0;
        tick(1); le[0] = 1'b0;
        chk("t4_ld_pc", o_pc[0], 16'h00F0);
        chk("t4_ld_novld", vcnt[0], c);
        st[0] = 1'b1; tick(1); tick(1);
        chk("t4_ir", o_ir[0], 16'hA555);
        chk("t4_pc", o_pc[0], 16'h00F1);
        st[0] = 1'b0; tick(2);
        c = vcnt[0];
        le[0] = 1'b1; la[0] = 16'h0020; st[0] = 1'b1;
        tick(1); le[0] = 1'b0;
        chk("t4_ldstep_pc", o_pc[0], 16'h0020);
        chk("t4_ldstep_busy", 32'(o_bz[0]), 32'd0);
        tick(2);
        chk("t4_step_dropped", vcnt[0], c);
        chk("t4_pc_held", o_pc[0], 16'h0020);
        st[0] = 1'b0; tick(1);

        // 5: latency 3, 4-bit PC wrap, pending step
        le[1] = 1'b1; la[1] = 16'h000F;
        tick(1); le[1] = 1'b0;
        chk("t5_ld", o_pc[1], 16'h000F);
        mr[1] = 1'b1;
        tick(1); chk("t5_busy", 32'(o_bz[1]), 32'd1);
        tick(2); chk("t5_wait", 32'(o_vl[1]), 32'd0); chk("t5_addr", o_ad[1], 16'h000F);
        tick(1); chk("t5_vld", 32'(o_vl[1]), 32'd1); chk("t5_ir", o_ir[1], 16'hA5AA); chk("t5_wrap", o_pc[1], 16'h0000);
        tick(4); chk("t5_period", 32'(o_vl[1]), 32'd1); chk("t5_ir2", o_ir[1], 16'hA5A5); chk("t5_pc1", o_pc[1], 16'h0001);
        mr[1] = 1'b0;
        tick(1);
        st[1] = 1'b1; tick(1);
        st[1] = 1'b0; tick(1);
        st[1] = 1'b1; tick(1);
        st[1] = 1'b0; tick(1);
        chk("t5_done", 32'(o_vl[1]), 32'd1); chk("t5_pc2", o_pc[1], 16'h0002);
        tick(1); chk("t5_pend_served", 32'(o_bz[1]), 32'd1);
        tick(3); chk("t5_pend_vld", 32'(o_vl[1]), 32'd1); chk("t5_pc3", o_pc[1], 16'h0003);
        tick(2);

        // 6: reset mid-fetch
        mr[0] = 1'b1; tick(1);
        chk("t6_busy_before", 32'(o_bz[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_pc", o_pc[0], 16'h0000);
        chk("t6_ir", o_ir[0], 16'h0000);
        chk("t6_busy", 32'(o_bz[0]), 32'd0);
        chk("t6_pc_narrow", o_pc[1], 16'h0000);
        mr[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        c = vcnt[0];
        tick(4);
        chk("t6_no_pulse", vcnt[0], c);
        chk("t6_pc_idle", o_pc[0], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
